// File: rtl/final_soc_game_cpu_cpu_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI RAM arbiter.
// Holds the FSM state encoding, RAM geometry and the grant encoding.
package final_soc_game_cpu_cpu_ocimem_arbiter_pkg;

  localparam int OCI_AW = 8;
  localparam int OCI_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_AV   = 1'b0,
    GNT_JTAG = 1'b1
  } gnt_e;

endpackage

// File: rtl/final_soc_game_cpu_cpu_ocimem_rr_arb2.sv
// Two-way round-robin arbiter between the Avalon and JTAG requesters.
// On a tie the requester not granted last wins; the history only moves when a grant is taken.
module final_soc_game_cpu_cpu_ocimem_rr_arb2
  import final_soc_game_cpu_cpu_ocimem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_av_i,
  input  logic req_jtag_i,
  input  logic advance_i,
  output logic gnt_o
);

  gnt_e last_q;
  gnt_e gnt_d;

  always_comb begin
    gnt_d = GNT_AV;
    if (req_av_i && req_jtag_i) begin
      gnt_d = (last_q == GNT_AV) ? GNT_JTAG : GNT_AV;
    end else if (req_jtag_i) begin
      gnt_d = GNT_JTAG;
    end
  end

  // Starting from an Avalon history gives JTAG the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_AV;
    end else if (advance_i && (req_av_i || req_jtag_i)) begin
      last_q <= gnt_d;
    end
  end

  assign gnt_o = gnt_d;

endmodule

// File: rtl/final_soc_game_cpu_cpu_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the JTAG debug command path and the Avalon debug_mem port.
// Every access is IDLE -> ISSUE (address phase) -> DONE (data phase), three cycles fixed.
module final_soc_game_cpu_cpu_ocimem_arbiter
  import final_soc_game_cpu_cpu_ocimem_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                jtag_req_valid,
  input  logic                jtag_req_write,
  input  logic [OCI_AW-1:0]   jtag_req_addr,
  input  logic [OCI_DW-1:0]   jtag_req_wdata,
  output logic                jtag_busy,
  output logic [OCI_DW-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  input  logic [OCI_AW-1:0]   av_address,
  input  logic                av_read,
  input  logic                av_write,
  input  logic [OCI_DW-1:0]   av_writedata,
  input  logic [3:0]          av_byteenable,
  output logic                av_waitrequest,
  output logic [OCI_DW-1:0]   av_readdata,
  output logic [OCI_AW-1:0]   mem_addr,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [OCI_DW-1:0]   mem_wdata,
  input  logic [OCI_DW-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  // Handshakes: the Avalon master holds av_read/av_write until it sees av_waitrequest low,
  // which lasts exactly one cycle (DONE); a JTAG command is a single-cycle jtag_req_valid pulse.
  state_e              state_q;
  gnt_e                gnt_q;
  logic                pend_q, jw_q;
  logic [OCI_AW-1:0]   ja_q;
  logic [OCI_DW-1:0]   jd_q;
  logic [OCI_DW-1:0]   mon_q;
  logic                ready_q, err_q, waitreq_q;
  logic [OCI_AW-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [3:0]          mem_be_q;
  logic [OCI_DW-1:0]   mem_wdata_q;

  logic                av_act, jtag_act, jtag_done, jtag_accept, jtag_drop;
  logic                arb_gnt;
  logic                j_write;
  logic [OCI_AW-1:0]   j_addr;
  logic [OCI_DW-1:0]   j_wdata;

  assign av_act      = av_read || av_write;
  assign jtag_act    = pend_q || jtag_req_valid;
  assign jtag_done   = (state_q == DONE) && (gnt_q == GNT_JTAG);
  assign jtag_accept = jtag_req_valid && (!pend_q || jtag_done);
  assign jtag_drop   = jtag_req_valid && !jtag_accept;

  // A fresh pulse in IDLE is served straight from the inputs so it costs no extra cycle.
  assign j_write = pend_q ? jw_q : jtag_req_write;
  assign j_addr  = pend_q ? ja_q : jtag_req_addr;
  assign j_wdata = pend_q ? jd_q : jtag_req_wdata;

  final_soc_game_cpu_cpu_ocimem_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_av_i   (av_act),
    .req_jtag_i (jtag_act),
    .advance_i  (state_q == IDLE),
    .gnt_o      (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_AV;
      pend_q      <= 1'b0;
      jw_q        <= 1'b0;
      ja_q        <= '0;
      jd_q        <= '0;
      mon_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      waitreq_q   <= 1'b1;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (jtag_accept) begin
        pend_q <= 1'b1;
        jw_q   <= jtag_req_write;
        ja_q   <= jtag_req_addr;
        jd_q   <= jtag_req_wdata;
        err_q  <= 1'b0;
      end else if (jtag_done) begin
        pend_q <= 1'b0;
      end
      if (jtag_drop) err_q <= 1'b1;

      if (jtag_accept)    ready_q <= 1'b0;
      else if (jtag_done) ready_q <= 1'b1;
      if (jtag_done && !jw_q) mon_q <= mem_rdata;

      case (state_q)
        IDLE: begin
          if (av_act || jtag_act) begin
            state_q  <= ISSUE;
            gnt_q    <= gnt_e'(arb_gnt);
            if (gnt_e'(arb_gnt) == GNT_JTAG) begin
              mem_addr_q  <= j_addr;
              mem_we_q    <= j_write;
              mem_be_q    <= 4'hF;
              mem_wdata_q <= j_write ? j_wdata : '0;
            end else begin
              mem_addr_q  <= av_address;
              mem_we_q    <= av_write;
              mem_be_q    <= av_byteenable;
              mem_wdata_q <= av_write ? av_writedata : '0;
            end
          end
        end
        ISSUE: begin
          state_q     <= DONE;
          mem_addr_q  <= '0;
          mem_we_q    <= 1'b0;
          mem_be_q    <= '0;
          mem_wdata_q <= '0;
          waitreq_q   <= (gnt_q != GNT_AV);
        end
        DONE: begin
          state_q   <= IDLE;
          waitreq_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign jtag_busy      = pend_q;
  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;
  assign av_waitrequest = waitreq_q;
  assign av_readdata    = waitreq_q ? '0 : mem_rdata;
  assign mem_addr       = mem_addr_q;
  assign mem_we         = mem_we_q;
  assign mem_be         = mem_be_q;
  assign mem_wdata      = mem_wdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_final_soc_game_cpu_cpu_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level memory model and a round-robin latency model.
module tb_final_soc_game_cpu_cpu_ocimem_arbiter;
  import final_soc_game_cpu_cpu_ocimem_arbiter_pkg::*;

  bit          clk = 1'b0;
  logic        reset;
  logic        jtag_req_valid, jtag_req_write;
  logic [7:0]  jtag_req_addr;
  logic [31:0] jtag_req_wdata;
  logic        jtag_busy;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [256];

  final_soc_game_cpu_cpu_ocimem_arbiter dut (
    .clk(clk), .reset(reset),
    .jtag_req_valid(jtag_req_valid), .jtag_req_write(jtag_req_write),
    .jtag_req_addr(jtag_req_addr), .jtag_req_wdata(jtag_req_wdata),
    .jtag_busy(jtag_busy), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h20) return 32'h12345678;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // OCI RAM: synchronous read, data one cycle after the address
  logic [31:0] ram [256];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_be);
    end
    mem_rdata <= ram[mem_addr];
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_mon;
  gnt_e        last;

  initial begin
    reset = 1'b1;
    jtag_req_valid = 0; jtag_req_write = 0; jtag_req_addr = 0; jtag_req_wdata = 0;
    av_address = 0; av_read = 0; av_write = 0; av_writedata = 0; av_byteenable = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    tick(); tick(); tick();

    chk("rst_waitreq", 32'(av_waitrequest), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(jtag_busy), 32'd0);
    chk("rst_ready", 32'(monitor_ready), 32'd0);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Avalon write 0x10 <= DEADBEEF, be 0011
    av_write = 1; av_address = 8'h10; av_writedata = 32'hDEADBEEF; av_byteenable = 4'b0011;
    chk("w_c0_wait", 32'(av_waitrequest), 32'd1);
    tick();
    chk("w_c1_we", 32'(mem_we), 32'd1);
    chk("w_c1_be", 32'(mem_be), 32'h3);
    chk("w_c1_addr", 32'(mem_addr), 32'h10);
    chk("w_c1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_c1_wait", 32'(av_waitrequest), 32'd1);
    tick();
    chk("w_c2_wait", 32'(av_waitrequest), 32'd0);
    ref_mem[8'h10] = merge(ref_mem[8'h10], 32'hDEADBEEF, 4'b0011);
    av_write = 0;
    tick();
    chk("w_c3_wait", 32'(av_waitrequest), 32'd1);
    chk("w_c3_we", 32'(mem_we), 32'd0);

    // JTAG read 0x20
    jtag_req_valid = 1; jtag_req_write = 0; jtag_req_addr = 8'h20;
    tick();
    jtag_req_valid = 0;
    chk("jr_c1_busy", 32'(jtag_busy), 32'd1);
    chk("jr_c1_addr", 32'(mem_addr), 32'h20);
    chk("jr_c1_we", 32'(mem_we), 32'd0);
    chk("jr_c1_be", 32'(mem_be), 32'hF);
    tick();
    chk("jr_c2_busy", 32'(jtag_busy), 32'd1);
    chk("jr_c2_ready", 32'(monitor_ready), 32'd0);
    tick();
    chk("jr_c3_busy", 32'(jtag_busy), 32'd0);
    chk("jr_c3_ready", 32'(monitor_ready), 32'd1);
    chk("jr_c3_mondreg", MonDReg, 32'h12345678);

    // simultaneous requests after reset: JTAG first, then alternation
    do_reset();
    jtag_req_valid = 1; jtag_req_write = 1; jtag_req_addr = 8'h30; jtag_req_wdata = 32'hA5A55A5A;
    av_read = 1; av_address = 8'h40; av_byteenable = 4'hF;
    tick();
    jtag_req_valid = 0;
    chk("tie1_addr", 32'(mem_addr), 32'h30);
    chk("tie1_we", 32'(mem_we), 32'd1);
    chk("tie1_wdata", mem_wdata, 32'hA5A55A5A);
    chk("tie1_wait", 32'(av_waitrequest), 32'd1);
    ref_mem[8'h30] = 32'hA5A55A5A;
    tick();
    chk("tie1_c2_wait", 32'(av_waitrequest), 32'd1);
    tick();
    chk("tie1_c3_ready", 32'(monitor_ready), 32'd1);
    jtag_req_valid = 1; jtag_req_write = 0; jtag_req_addr = 8'h34;
    tick();
    jtag_req_valid = 0;
    chk("tie2_addr", 32'(mem_addr), 32'h40);
    chk("tie2_we", 32'(mem_we), 32'd0);
    chk("tie2_busy", 32'(jtag_busy), 32'd1);
    tick();
    chk("tie2_wait", 32'(av_waitrequest), 32'd0);
    chk("tie2_rdata", av_readdata, ref_mem[8'h40]);
    av_read = 0;
    tick();
    chk("tie2_c6_wait", 32'(av_waitrequest), 32'd1);
    tick();
    chk("tie3_addr", 32'(mem_addr), 32'h34);
    tick(); tick();
    chk("tie3_ready", 32'(monitor_ready), 32'd1);
    chk("tie3_mondreg", MonDReg, ref_mem[8'h34]);

    // command arriving in the DONE cycle of the previous one is accepted
    jtag_req_valid = 1; jtag_req_write = 0; jtag_req_addr = 8'h20;
    tick();
    jtag_req_valid = 0;
    tick();
    jtag_req_valid = 1; jtag_req_addr = 8'h10;
    tick();
    jtag_req_valid = 0;
    chk("done_acc_err", 32'(monitor_error), 32'd0);
    chk("done_acc_busy", 32'(jtag_busy), 32'd1);
    chk("done_acc_mon", MonDReg, 32'h12345678);
    tick();
    chk("done_acc_addr", 32'(mem_addr), 32'h10);
    tick(); tick();
    chk("done_acc_mon2", MonDReg, ref_mem[8'h10]);

    // command dropped while one is pending
    jtag_req_valid = 1; jtag_req_write = 0; jtag_req_addr = 8'h20;
    tick();
    jtag_req_addr = 8'h99;
    tick();
    jtag_req_valid = 0;
    chk("drop_err", 32'(monitor_error), 32'd1);
    chk("drop_busy", 32'(jtag_busy), 32'd1);
    tick();
    chk("drop_mon", MonDReg, 32'h12345678);
    chk("drop_ready", 32'(monitor_ready), 32'd1);
    chk("drop_err_hold", 32'(monitor_error), 32'd1);
    jtag_req_valid = 1; jtag_req_addr = 8'h30;
    tick();
    jtag_req_valid = 0;
    chk("drop_err_clr", 32'(monitor_error), 32'd0);
    chk("drop_ready_clr", 32'(monitor_ready), 32'd0);
    chk("drop_next_addr", 32'(mem_addr), 32'h30);
    tick(); tick();
    chk("drop_next_mon", MonDReg, 32'hA5A55A5A);

    // reset during ISSUE of a write, with a JTAG command arriving
    av_write = 1; av_address = 8'h50; av_writedata = 32'h0BADF00D; av_byteenable = 4'hF;
    tick();
    chk("rmid_we", 32'(mem_we), 32'd1);
    reset = 1; jtag_req_valid = 1; jtag_req_write = 0; jtag_req_addr = 8'h60;
    ref_mem[8'h50] = 32'h0BADF00D;
    tick();
    reset = 0; jtag_req_valid = 0; av_write = 0;
    chk("rmid_we0", 32'(mem_we), 32'd0);
    chk("rmid_addr", 32'(mem_addr), 32'd0);
    chk("rmid_be", 32'(mem_be), 32'd0);
    chk("rmid_wdata", mem_wdata, 32'd0);
    chk("rmid_wait", 32'(av_waitrequest), 32'd1);
    chk("rmid_busy", 32'(jtag_busy), 32'd0);
    chk("rmid_ready", 32'(monitor_ready), 32'd0);
    chk("rmid_mon", MonDReg, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rmid_idle_we", 32'(mem_we), 32'd0);
      chk("rmid_idle_addr", 32'(mem_addr), 32'd0);
    end

    // randomized traffic: Avalon in 0x00-0x7F, JTAG in 0x80-0xFF
    exp_mon = 32'd0;
    last = GNT_AV;
    for (int it = 0; it < 40; it++) begin
      int unsigned mode, kind, c, exp_av_c, exp_j_c;
      bit use_av, use_j, jtag_first, av_is_read, av_done, j_done;
      logic [7:0] aa, ja;
      logic [31:0] ad, jd;
      logic [3:0] be;
      bit jw;
      mode = $urandom_range(1, 3);
      use_av = mode[0]; use_j = mode[1];
      kind = $urandom_range(0, 2);
      aa = 8'($urandom_range(0, 127)); ad = $urandom; be = 4'($urandom_range(1, 15));
      ja = 8'($urandom_range(128, 255)); jd = $urandom; jw = 1'($urandom_range(0, 1));
      av_is_read = (kind == 0);

      jtag_first = use_j && (!use_av || last == GNT_AV);
      if (use_av && use_j) last = jtag_first ? GNT_AV : GNT_JTAG;
      else if (use_av) last = GNT_AV;
      else last = GNT_JTAG;
      exp_av_c = (use_j && jtag_first) ? 5 : 2;
      exp_j_c  = (use_av && !jtag_first) ? 6 : 3;

      if (use_av) begin
        if (av_is_read) exp_q.push_back(ref_mem[aa]);
        else ref_mem[aa] = merge(ref_mem[aa], ad, be);
        av_address = aa; av_writedata = ad; av_byteenable = be;
        av_read = (kind != 1); av_write = (kind != 0);
      end
      if (use_j) begin
        if (!jw) exp_mon = ref_mem[ja];
        else ref_mem[ja] = jd;
        jtag_req_valid = 1; jtag_req_write = jw; jtag_req_addr = ja; jtag_req_wdata = jd;
      end
      tick();
      jtag_req_valid = 0;
      av_done = !use_av; j_done = !use_j;
      c = 1;
      while (!(av_done && j_done) && c <= 12) begin
        if (!av_done && !av_waitrequest) begin
          chk("rnd_av_lat", c, exp_av_c);
          if (av_is_read) begin
            if (exp_q.size() > 0) chk("rnd_av_rdata", av_readdata, exp_q.pop_front());
            else chk("rnd_av_q_empty", 32'd0, 32'd1);
          end
          av_read = 0; av_write = 0; av_done = 1;
        end
        if (!j_done && monitor_ready) begin
          chk("rnd_j_lat", c, exp_j_c);
          chk("rnd_j_mon", MonDReg, exp_mon);
          j_done = 1;
        end
        tick();
        c++;
      end
      chk("rnd_av_done", 32'(av_done), 32'd1);
      chk("rnd_j_done", 32'(j_done), 32'd1);
      av_read = 0; av_write = 0;
      tick();
    end
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
